// File: rtl/sd_loader_pkg.sv
// Shared types and constants for the SD sector stream loader.
// The PREAMBLE state only exists when SDLOAD_PREAMBLE_EN is defined.
package sd_loader_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] DEFAULT_EOF = 8'h1A;

`ifdef SDLOAD_PREAMBLE_EN
    typedef enum logic [2:0] {IDLE, PREAMBLE, REQ, WAIT_ACK, FETCH, SEND, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, FETCH, SEND, DONE} state_t;
`endif

endpackage

// File: rtl/sd_stream_loader.sv
// Streams SD sectors byte-by-byte to a valid/ready sink until an EOF byte.
// Optional ASCII digit preamble built only when SDLOAD_PREAMBLE_EN is defined.
module sd_stream_loader
    import sd_loader_pkg::*;
#(
    parameter int         SECTOR_BYTES = 512,
    parameter int         LBA_W        = 9,
    parameter int         MAX_SECTORS  = 512,
    parameter logic [7:0] EOF_BYTE     = DEFAULT_EOF,
    parameter int         PREAMBLE_LEN = 10,
    localparam int        AW           = $clog2(SECTOR_BYTES)
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    input  logic             sd_ack,
    output logic [AW-1:0]    buf_addr,
    input  logic [7:0]       buf_dout,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LBA_W-1:0] sector_count
);

    localparam logic [AW-1:0]    LAST_ADDR = AW'(SECTOR_BYTES - 1);
    localparam logic [LBA_W-1:0] LAST_SECT = LBA_W'(MAX_SECTORS - 1);

    if (SECTOR_BYTES < 64 || SECTOR_BYTES > 4096 || (SECTOR_BYTES & (SECTOR_BYTES - 1)) != 0 ||
        MAX_SECTORS < 1 || MAX_SECTORS > (1 << LBA_W) || PREAMBLE_LEN < 1 || PREAMBLE_LEN > 10)
    begin : g_bad_cfg
        $error("sd_stream_loader: parameter out of range");
    end

    state_t           r_state, w_next;
    logic             r_sd_rd, r_tx_valid, r_busy, r_done, r_error;
    logic             r_ack_seen, r_abort_pend, r_fetch_wait;
    logic [7:0]       r_tx_data;
    logic [LBA_W-1:0] r_lba, r_count;
    logic [AW-1:0]    r_addr;
    logic             w_accept, w_last, w_at_max, w_ack_fall;

    assign w_accept   = r_tx_valid & tx_ready;
    assign w_last     = (r_addr == LAST_ADDR);
    assign w_at_max   = (r_count == LAST_SECT);
    assign w_ack_fall = r_ack_seen & ~sd_ack;

`ifdef SDLOAD_PREAMBLE_EN
    logic [3:0] r_pre_idx;
    logic       w_pre_last;
    assign w_pre_last = (r_pre_idx == 4'(PREAMBLE_LEN - 1));
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) begin
`ifdef SDLOAD_PREAMBLE_EN
                w_next = PREAMBLE;
`else
                w_next = REQ;
`endif
            end
`ifdef SDLOAD_PREAMBLE_EN
            PREAMBLE: begin
                if (abort)                       w_next = DONE;
                else if (w_accept && w_pre_last) w_next = REQ;
            end
`endif
            REQ:      w_next = WAIT_ACK;
            // An abort here is deferred so the host's fill cycle always completes.
            WAIT_ACK: if (w_ack_fall) w_next = (r_abort_pend || abort) ? DONE : FETCH;
            FETCH: begin
                if (abort)              w_next = DONE;
                else if (!r_fetch_wait) w_next = (buf_dout == EOF_BYTE) ? DONE : SEND;
            end
            SEND: begin
                if (abort)         w_next = DONE;
                else if (w_accept) w_next = !w_last ? FETCH : (w_at_max ? DONE : REQ);
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_sd_rd      <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_lba        <= '0;
            r_count      <= '0;
            r_addr       <= '0;
            r_ack_seen   <= 1'b0;
            r_abort_pend <= 1'b0;
            r_fetch_wait <= 1'b0;
`ifdef SDLOAD_PREAMBLE_EN
            r_pre_idx    <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_error      <= 1'b0;
                    r_lba        <= '0;
                    r_count      <= '0;
                    r_addr       <= '0;
                    r_busy       <= 1'b1;
                    r_ack_seen   <= 1'b0;
                    r_abort_pend <= 1'b0;
                    r_fetch_wait <= 1'b0;
`ifdef SDLOAD_PREAMBLE_EN
                    r_tx_data    <= ASCII_ZERO;
                    r_tx_valid   <= 1'b1;
                    r_pre_idx    <= '0;
`endif
                end
`ifdef SDLOAD_PREAMBLE_EN
                PREAMBLE: begin
                    if (abort) begin
                        r_tx_valid <= 1'b0;
                        r_error    <= 1'b1;
                    end else if (w_accept) begin
                        if (w_pre_last) begin
                            r_tx_valid <= 1'b0;
                        end else begin
                            r_pre_idx <= r_pre_idx + 4'd1;
                            r_tx_data <= ASCII_ZERO + {4'd0, r_pre_idx + 4'd1};
                        end
                    end
                end
`endif
                REQ: begin
                    r_sd_rd <= 1'b1;
                    if (abort) r_abort_pend <= 1'b1;
                end
                WAIT_ACK: begin
                    if (abort) r_abort_pend <= 1'b1;
                    if (sd_ack) begin
                        r_ack_seen <= 1'b1;
                        r_sd_rd    <= 1'b0;
                    end else if (r_ack_seen) begin
                        r_ack_seen   <= 1'b0;
                        r_addr       <= '0;
                        r_fetch_wait <= 1'b1;
                        if (r_abort_pend || abort) r_error <= 1'b1;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        r_error <= 1'b1;
                    end else if (r_fetch_wait) begin
                        r_fetch_wait <= 1'b0;
                    end else if (buf_dout != EOF_BYTE) begin
                        r_tx_data  <= buf_dout;
                        r_tx_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (abort) begin
                        r_tx_valid <= 1'b0;
                        r_error    <= 1'b1;
                    end else if (w_accept) begin
                        r_tx_valid <= 1'b0;
                        if (w_last) begin
                            r_addr <= '0;
                            if (w_at_max) begin
                                r_error <= 1'b1;
                            end else begin
                                r_count <= r_count + 1'b1;
                                r_lba   <= r_lba + 1'b1;
                            end
                        end else begin
                            r_addr       <= r_addr + 1'b1;
                            r_fetch_wait <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_busy <= 1'b0;
                    r_done <= ~r_error;
                end
                default: ;
            endcase
        end
    end

    assign sd_rd        = r_sd_rd;
    assign sd_lba       = r_lba;
    assign buf_addr     = r_addr;
    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign sector_count = r_count;

endmodule

// File: tb/tb_sd_stream_loader.sv
// Directed bench for sd_stream_loader: default instance plus a MAX_SECTORS=2 instance.
module tb_sd_stream_loader;

    localparam int SB = 512;
`ifdef SDLOAD_PREAMBLE_EN
    localparam int PRE = 10;
`else
    localparam int PRE = 0;
`endif

    logic       clk_sys = 1'b0;
    logic       reset_n;
    always #5 clk_sys = ~clk_sys;

    // default instance
    logic       start, abort, sd_ack, tx_ready, sd_rd, tx_valid, busy, done, error;
    logic [8:0] sd_lba, buf_addr, sector_count;
    logic [7:0] buf_dout, tx_data;
    // MAX_SECTORS=2 instance
    logic       start_m, abort_m, sd_ack_m, tx_ready_m, sd_rd_m, tx_valid_m, busy_m, done_m, error_m;
    logic [8:0] sd_lba_m, buf_addr_m, sector_count_m;
    logic [7:0] buf_dout_m, tx_data_m;

    int         n_cmp, n_bad, pat, done_cnt, done_cnt_m;
    logic [7:0] rx_q[$], rx_m[$];
    int         lba_log[$], lba_log_m[$];
    logic [7:0] sbuf[SB], sbuf_m[SB];

    sd_stream_loader dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .abort(abort),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_ack(sd_ack), .buf_addr(buf_addr), .buf_dout(buf_dout),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done),
        .error(error), .sector_count(sector_count));

    sd_stream_loader #(.MAX_SECTORS(2)) dut_m (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start_m), .abort(abort_m),
        .sd_lba(sd_lba_m), .sd_rd(sd_rd_m), .sd_ack(sd_ack_m), .buf_addr(buf_addr_m), .buf_dout(buf_dout_m),
        .tx_data(tx_data_m), .tx_valid(tx_valid_m), .tx_ready(tx_ready_m), .busy(busy_m), .done(done_m),
        .error(error_m), .sector_count(sector_count_m));

    function automatic logic [7:0] pat_byte(input int mode, input int lba, input int off);
        case (mode)
            0:       return (lba != 0) ? 8'h1A : (off == 0) ? 8'h41 : (off == 1) ? 8'h42 : 8'h1A;
            1:       return (lba == 2 && off == 3) ? 8'h1A : 8'h55;
            3:       return (off < 10) ? 8'h60 + 8'(off) : 8'h1A;
            default: return 8'h55;
        endcase
    endfunction

    // Host models: sync-read sector buffers, ack pulse 2 cycles after sd_rd.
    always @(posedge clk_sys) buf_dout   <= sbuf[buf_addr];
    always @(posedge clk_sys) buf_dout_m <= sbuf_m[buf_addr_m];

    initial begin
        sd_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            if (sd_rd === 1'b1 && sd_ack == 1'b0) begin
                lba_log.push_back(int'(sd_lba));
                repeat (2) @(posedge clk_sys);
                #1 sd_ack = 1'b1;
                for (int i = 0; i < SB; i++) sbuf[i] = pat_byte(pat, int'(sd_lba), i);
                repeat (4) @(posedge clk_sys);
                #1 sd_ack = 1'b0;
            end
        end
    end

    initial begin
        sd_ack_m = 1'b0;
        forever begin
            @(posedge clk_sys);
            if (sd_rd_m === 1'b1 && sd_ack_m == 1'b0) begin
                lba_log_m.push_back(int'(sd_lba_m));
                repeat (2) @(posedge clk_sys);
                #1 sd_ack_m = 1'b1;
                for (int i = 0; i < SB; i++) sbuf_m[i] = pat_byte(2, int'(sd_lba_m), i);
                repeat (4) @(posedge clk_sys);
                #1 sd_ack_m = 1'b0;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (tx_valid && tx_ready)     rx_q.push_back(tx_data);
        if (tx_valid_m && tx_ready_m) rx_m.push_back(tx_data_m);
        if (done)   done_cnt++;
        if (done_m) done_cnt_m++;
    end

    task automatic clear_logs();
        rx_q.delete(); rx_m.delete(); lba_log.delete(); lba_log_m.delete();
        done_cnt = 0; done_cnt_m = 0;
    endtask

    task automatic pulse_start(input bit m);
        @(posedge clk_sys); #1;
        if (m) start_m = 1'b1; else start = 1'b1;
        @(posedge clk_sys); #1;
        start_m = 1'b0; start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge clk_sys); #1 abort = 1'b1;
        @(posedge clk_sys); #1 abort = 1'b0;
    endtask

    task automatic wait_idle(input bit m, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk_sys);
            if ((m ? busy_m : busy) == 1'b0) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        n_cmp++; if ({sd_rd, tx_valid, busy, done, error} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {sd_rd, tx_valid, busy, done, error}); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_cmp++; if (sd_lba !== 9'd0) begin n_bad++; $display("FAIL reset_sd_lba: got %0d want 0", sd_lba); end
        n_cmp++; if (buf_addr !== 9'd0) begin n_bad++; $display("FAIL reset_buf_addr: got %0d want 0", buf_addr); end
        n_cmp++; if (sector_count !== 9'd0) begin n_bad++; $display("FAIL reset_sector_count: got %0d want 0", sector_count); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        n_cmp++; if ({busy, busy_m, done} !== 3'b0) begin n_bad++; $display("FAIL idle_after_reset: got %b want 000", {busy, busy_m, done}); end
    endtask

    task automatic test_basic();
        bit ok; int nb; logic [7:0] exp[$];
        pat = 0; clear_logs();
        pulse_start(0);
        @(negedge clk_sys);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_idle(0, 1000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_timeout: got %b want 1", ok); end
        for (int i = 0; i < PRE; i++) exp.push_back(8'h30 + 8'(i));
        exp.push_back(8'h41); exp.push_back(8'h42);
        nb = 0;
        for (int i = 0; i < exp.size(); i++) if (i >= rx_q.size() || rx_q[i] !== exp[i]) nb++;
        n_cmp++; if (rx_q.size() != exp.size()) begin n_bad++; $display("FAIL basic_len: got %0d want %0d", rx_q.size(), exp.size()); end
        n_cmp++; if (nb != 0) begin n_bad++; $display("FAIL basic_bytes: got %0d bad want 0", nb); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL basic_error: got %b want 0", error); end
        n_cmp++; if (sector_count !== 9'd0) begin n_bad++; $display("FAIL basic_count: got %0d want 0", sector_count); end
        n_cmp++; if (lba_log.size() != 1) begin n_bad++; $display("FAIL basic_reads: got %0d want 1", lba_log.size()); end
    endtask

    task automatic test_two_sectors();
        bit ok; int nb;
        pat = 1; clear_logs();
        pulse_start(0);
        wait_idle(0, 6000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL two_timeout: got %b want 1", ok); end
        n_cmp++; if (rx_q.size() != PRE + 1027) begin n_bad++; $display("FAIL two_len: got %0d want %0d", rx_q.size(), PRE + 1027); end
        nb = 0;
        for (int i = PRE; i < rx_q.size(); i++) if (rx_q[i] !== 8'h55) nb++;
        n_cmp++; if (nb != 0) begin n_bad++; $display("FAIL two_bytes: got %0d bad want 0", nb); end
        n_cmp++; if (lba_log.size() != 3) begin n_bad++; $display("FAIL two_reads: got %0d want 3", lba_log.size()); end
        nb = 0;
        for (int i = 0; i < lba_log.size(); i++) if (lba_log[i] != i) nb++;
        n_cmp++; if (nb != 0) begin n_bad++; $display("FAIL two_lba_seq: got %0d bad want 0", nb); end
        n_cmp++; if (sector_count !== 9'd2) begin n_bad++; $display("FAIL two_count: got %0d want 2", sector_count); end
        n_cmp++; if (done_cnt != 1 || error !== 1'b0) begin n_bad++; $display("FAIL two_done: got done=%0d err=%b want 1/0", done_cnt, error); end
    endtask

    task automatic test_backpressure();
        bit ok; int nb, idx; logic [7:0] held; logic [7:0] exp[$];
        pat = 3; clear_logs();
        for (int i = 0; i < PRE; i++) exp.push_back(8'h30 + 8'(i));
        for (int i = 0; i < 10; i++) exp.push_back(8'h60 + 8'(i));
        pulse_start(0);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_sys);
            if (rx_q.size() >= PRE + 4) begin ok = 1'b1; break; end
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_reach: got %b want 1", ok); end
        @(posedge clk_sys); #1 tx_ready = 1'b0;
        repeat (3) @(negedge clk_sys);
        held = tx_data; idx = rx_q.size();
        n_cmp++; if (idx >= exp.size() || held !== exp[idx]) begin n_bad++; $display("FAIL bp_held: got %h at %0d", held, idx); end
        nb = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_sys);
            if (tx_valid !== 1'b1 || tx_data !== held) nb++;
        end
        n_cmp++; if (nb != 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", nb); end
        n_cmp++; if (rx_q.size() != idx) begin n_bad++; $display("FAIL bp_no_accept: got %0d want %0d", rx_q.size(), idx); end
        @(posedge clk_sys); #1 tx_ready = 1'b1;
        wait_idle(0, 500, ok);
        nb = 0;
        for (int i = 0; i < exp.size(); i++) if (i >= rx_q.size() || rx_q[i] !== exp[i]) nb++;
        n_cmp++; if (rx_q.size() != exp.size() || nb != 0) begin n_bad++; $display("FAIL bp_stream: got len %0d bad %0d want len %0d bad 0", rx_q.size(), nb, exp.size()); end
    endtask

    task automatic test_max_sectors();
        bit ok;
        clear_logs();
        pulse_start(1);
        wait_idle(1, 6000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL max_timeout: got %b want 1", ok); end
        n_cmp++; if (error_m !== 1'b1) begin n_bad++; $display("FAIL max_error: got %b want 1", error_m); end
        n_cmp++; if (done_cnt_m != 0) begin n_bad++; $display("FAIL max_done: got %0d pulses want 0", done_cnt_m); end
        n_cmp++; if (lba_log_m.size() != 2) begin n_bad++; $display("FAIL max_reads: got %0d want 2", lba_log_m.size()); end
        n_cmp++; if (rx_m.size() != PRE + 1024) begin n_bad++; $display("FAIL max_len: got %0d want %0d", rx_m.size(), PRE + 1024); end
        n_cmp++; if (sector_count_m !== 9'd1) begin n_bad++; $display("FAIL max_count: got %0d want 1", sector_count_m); end
    endtask

    task automatic test_abort_wait_ack();
        bit ok, got;
        pat = 1; clear_logs();
        pulse_start(0);
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_sys);
            if (sd_ack) begin got = 1'b1; break; end
        end
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL abort_ack_seen: got %b want 1", got); end
        pulse_abort();
        wait_idle(0, 200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL abort_timeout: got %b want 1", ok); end
        n_cmp++; if (sd_ack !== 1'b0 || error !== 1'b1) begin n_bad++; $display("FAIL abort_state: got ack=%b err=%b want 0/1", sd_ack, error); end
        n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt); end
        n_cmp++; if (rx_q.size() != PRE) begin n_bad++; $display("FAIL abort_bytes: got %0d want %0d", rx_q.size(), PRE); end
        pat = 0; clear_logs();
        pulse_start(0);
        @(negedge clk_sys);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL abort_err_clear: got %b want 0", error); end
        wait_idle(0, 1000, ok);
        n_cmp++; if (done_cnt != 1 || error !== 1'b0) begin n_bad++; $display("FAIL abort_rerun: got done=%0d err=%b want 1/0", done_cnt, error); end
    endtask

    task automatic test_reset_mid();
        bit ok, got;
        pat = 1; clear_logs();
        pulse_start(0);
        got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_sys);
            if (tx_valid && rx_q.size() >= PRE + 5) begin got = 1'b1; break; end
        end
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL rst_reach_send: got %b want 1", got); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({sd_rd, tx_valid, busy, done, error, tx_data, sd_lba, buf_addr, sector_count} !== '0) begin
            n_bad++; $display("FAIL rst_async: got valid=%b busy=%b data=%h addr=%0d want all 0", tx_valid, busy, tx_data, buf_addr); end
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt); end
        pat = 0; clear_logs();
        pulse_start(0);
        wait_idle(0, 1000, ok);
        n_cmp++; if (lba_log.size() != 1 || lba_log[0] != 0) begin n_bad++; $display("FAIL rst_restart_lba: got %0d reads want 1 at lba 0", lba_log.size()); end
        n_cmp++; if (rx_q.size() != PRE + 2 || done_cnt != 1) begin n_bad++; $display("FAIL rst_restart: got len %0d done %0d want %0d/1", rx_q.size(), done_cnt, PRE + 2); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_bad = 0; pat = 0; done_cnt = 0; done_cnt_m = 0;
        start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
        start_m = 1'b0; abort_m = 1'b0; tx_ready_m = 1'b1;
        test_reset();
        test_basic();
        test_two_sectors();
        test_backpressure();
        test_max_sectors();
        test_abort_wait_ack();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
